seq_match_ctrl: RTL and testbench
=================================

Name: seq_match_ctrl

Overview:
Run-time programmable controller for the serial sequence detector path. It sequences one detection run at a time:
- latches a configuration (pattern, length, overlap mode, match target);
- arms on start, then shifts the qualified serial input w into a history register;
- compares against the pattern, pulses z on each hit and counts hits;
- terminates on target, stop or reset.

It sits between the stimulus/control logic and the detector output consumers, replacing hard-wired single-pattern detectors.

Parameters:
MAXLEN, 8, maximum pattern length in bits (2..16).
CNT_W, 8, width of match counter and target.
LEN_W, 4, width of cfg_len; must hold MAXLEN (clog2(MAXLEN)+1).

Ports:
clk  in  1  system clock, all state updates on rising edge.
rst  in  1  synchronous active-high reset.
cfg_we  in  1  config write strobe; honoured only in IDLE.
cfg_pattern  in  MAXLEN  pattern; bit [len-1] is the oldest bit, bit 0 the newest.
cfg_len  in  LEN_W  pattern length; valid range 1..MAXLEN.
cfg_overlap  in  1  1 = overlapping matches allowed.
cfg_target  in  CNT_W  stop after this many matches; 0 = run until stop.
start  in  1  arm a run (IDLE or DONE).
stop  in  1  abort a run (RUN).
w  in  1  serial data bit.
w_valid  in  1  w qualifier; bits with w_valid=0 are ignored.
z  out  1  one-cycle match pulse.
match_count  out  CNT_W  matches in current/last run.
busy  out  1  high in RUN.
done  out  1  high in DONE.

Behaviour:
Reset (synchronous, rst=1 at a clk edge):
- state=IDLE; z=0, match_count=0, busy=0, done=0.
- Config registers cleared: pattern=0, len=0, overlap=0, target=0.
- History and fill counter cleared.
- Applies identically mid-run; any partial history is lost.

State machine (IDLE, RUN, DONE):
- IDLE:
  - cfg_we=1: latch all cfg_* next cycle. cfg_we has priority; start in the same cycle is ignored.
  - start=1 with latched len in 1..MAXLEN: go to RUN; clear history, fill count and match_count.
  - start with len=0 or len>MAXLEN: ignored, stay IDLE.
- RUN:
  - Each cycle with w_valid=1: hist_next = {hist[MAXLEN-2:0], w}; fill = min(fill+1, len).
  - Hit when fill (after increment) == len and hist_next[len-1:0] == pattern[len-1:0].
  - On a hit:
    - z=1 in the following cycle, for exactly one cycle (latency 1 from the completing valid bit).
    - match_count increments in that same next cycle; it saturates at all-ones when target=0.
    - overlap=0: fill resets to 0, so the next hit needs len fresh bits.
    - overlap=1: fill stays at len.
    - target!=0 and the incremented count == target: go to DONE.
  - stop=1: go to IDLE. match_count is retained. A simultaneous w_valid bit is discarded; stop wins, so no hit is reported that cycle.
  - start in RUN: ignored. cfg_we in RUN: ignored.
- DONE:
  - done=1, busy=0; w ignored; match_count held.
  - start=1 re-arms into RUN (count cleared).
  - cfg_we is not honoured; config changes need rst or a stop path. stop in DONE goes to IDLE.

General rules:
- z is 0 in every state except the cycle after a hit.
- busy and done are registered and mutually exclusive.
- Pattern bits above len-1 are don't-care.

Test Plan:
1. Overlap hit: cfg pattern=4'b1011, len=4, overlap=1, target=0; start; stream 1,0,1,1,0,1,1 (all valid) -> z pulses after bits 4 and 7; match_count=2; busy=1 throughout.
2. Non-overlap: same stream with overlap=0 -> single z after bit 4; match_count=1; bits 5-7 do not hit.
3. Target and re-arm: target=2, overlap=1, same stream -> DONE after 2nd hit (done=1, busy=0, count=2). Further 1011 input gives no z. Then start -> RUN with count=0.
4. Valid gaps and stop: pattern 3'b111, len=3. Stream 1,1,(w_valid=0 w=0),1 -> hit. Then stop asserted together with a valid completing bit -> no z, state IDLE, count stays 1.
5. Invalid config: cfg_len=0 then start -> busy stays 0, z never asserts. cfg_we and start in the same cycle -> config updated, run not started.
6. Reset mid-run: rst after 2 bits of a 4-bit pattern -> next cycle all outputs 0 and config cleared. Start before reconfig is ignored.

Source files
------------

// File: rtl/seq_match_ctrl.sv
// Run-time programmable serial sequence detector controller.
// Latches a pattern configuration, arms on start, counts hits and stops on target, stop or reset.
module seq_match_ctrl #(
  parameter int MAXLEN = 8,
  parameter int CNT_W  = 8,
  parameter int LEN_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [MAXLEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic              cfg_overlap,
  input  logic [CNT_W-1:0]  cfg_target,
  input  logic              start,
  input  logic              stop,
  input  logic              w,
  input  logic              w_valid,
  output logic              z,
  output logic [CNT_W-1:0]  match_count,
  output logic              busy,
  output logic              done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        state_reg, state_next;
  logic [MAXLEN-1:0] pat_reg, pat_next;
  logic [LEN_W-1:0]  len_reg, len_next;
  logic              ovl_reg, ovl_next;
  logic [CNT_W-1:0]  tgt_reg, tgt_next;
  logic [MAXLEN-1:0] hist_reg, hist_next;
  logic [LEN_W-1:0]  fill_reg, fill_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              z_reg, z_next;
  logic              busy_reg, busy_next;
  logic              done_reg, done_next;

  logic [MAXLEN-1:0] len_mask;
  logic [MAXLEN-1:0] hist_shift;
  logic [LEN_W-1:0]  fill_inc;
  logic [CNT_W-1:0]  cnt_inc;
  logic              len_ok;
  logic              hit;

  // Only the lowest len bits of history and pattern take part in the compare.
  genvar gi;
  generate
    for (gi = 0; gi < MAXLEN; gi++) begin : g_mask
      assign len_mask[gi] = (len_reg > LEN_W'(gi));
    end
  endgenerate

  assign hist_shift = {hist_reg[MAXLEN-2:0], w};
  assign fill_inc   = (fill_reg >= len_reg) ? len_reg : fill_reg + LEN_W'(1);
  assign cnt_inc    = (cnt_reg == '1) ? cnt_reg : cnt_reg + CNT_W'(1);
  assign len_ok     = (len_reg != '0) && (len_reg <= LEN_W'(MAXLEN));

  // stop wins over a simultaneous valid bit, so that bit can never complete a hit.
  assign hit = (state_reg == S_RUN) && w_valid && !stop && (fill_inc == len_reg) &&
               (((hist_shift ^ pat_reg) & len_mask) == '0);

  always_comb begin
    state_next = state_reg;
    pat_next   = pat_reg;
    len_next   = len_reg;
    ovl_next   = ovl_reg;
    tgt_next   = tgt_reg;
    hist_next  = hist_reg;
    fill_next  = fill_reg;
    cnt_next   = cnt_reg;
    z_next     = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (cfg_we) begin
          pat_next = cfg_pattern;
          len_next = cfg_len;
          ovl_next = cfg_overlap;
          tgt_next = cfg_target;
        end else if (start && len_ok) begin
          state_next = S_RUN;
          hist_next  = '0;
          fill_next  = '0;
          cnt_next   = '0;
        end
      end
      S_RUN: begin
        if (stop) begin
          state_next = S_IDLE;
        end else if (w_valid) begin
          hist_next = hist_shift;
          fill_next = fill_inc;
          if (hit) begin
            z_next   = 1'b1;
            cnt_next = cnt_inc;
            if (!ovl_reg) fill_next = '0;
            if ((tgt_reg != '0) && (cnt_inc == tgt_reg)) state_next = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (start) begin
          state_next = S_RUN;
          hist_next  = '0;
          fill_next  = '0;
          cnt_next   = '0;
        end else if (stop) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
    busy_next = (state_next == S_RUN);
    done_next = (state_next == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
      pat_reg   <= '0;
      len_reg   <= '0;
      ovl_reg   <= 1'b0;
      tgt_reg   <= '0;
      hist_reg  <= '0;
      fill_reg  <= '0;
      cnt_reg   <= '0;
      z_reg     <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      pat_reg   <= pat_next;
      len_reg   <= len_next;
      ovl_reg   <= ovl_next;
      tgt_reg   <= tgt_next;
      hist_reg  <= hist_next;
      fill_reg  <= fill_next;
      cnt_reg   <= cnt_next;
      z_reg     <= z_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
    end
  end

  assign z           = z_reg;
  assign match_count = cnt_reg;
  assign busy        = busy_reg;
  assign done        = done_reg;

endmodule

// File: tb/tb_seq_match_ctrl.sv
// Scenario bench for seq_match_ctrl: each cycle pushes its expected {z,count,busy,done}
// and the observed outputs are compared in order by the owning scenario task.
module tb_seq_match_ctrl;
  localparam int MAXLEN = 8;
  localparam int CNT_W  = 8;
  localparam int LEN_W  = 4;

  logic              clk = 1'b0;
  logic              rst, cfg_we, cfg_overlap, start, stop, w, w_valid;
  logic [MAXLEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]  cfg_len;
  logic [CNT_W-1:0]  cfg_target;
  logic              z, busy, done;
  logic [CNT_W-1:0]  match_count;

  int errors = 0;
  int checks = 0;
  logic [CNT_W+2:0] exp_q[$];
  logic [CNT_W+2:0] act_q[$];
  logic [CNT_W+2:0] e, a;
  logic [CNT_W-1:0] c;

  seq_match_ctrl #(.MAXLEN(MAXLEN), .CNT_W(CNT_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .cfg_target(cfg_target), .start(start), .stop(stop),
    .w(w), .w_valid(w_valid), .z(z), .match_count(match_count), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic clear_pulses();
    rst = 0; cfg_we = 0; start = 0; stop = 0; w = 0; w_valid = 0;
  endtask

  // Queue the expectation for this cycle, clock once, capture outputs #1 after the edge.
  task automatic cycle(input logic ez, input logic [CNT_W-1:0] ecnt, input logic eb, input logic ed);
    exp_q.push_back({ez, ecnt, eb, ed});
    @(posedge clk);
    #1;
    act_q.push_back({z, match_count, busy, done});
    clear_pulses();
  endtask

  task automatic configure(input logic [MAXLEN-1:0] p, input logic [LEN_W-1:0] l,
                           input logic o, input logic [CNT_W-1:0] t,
                           input logic [CNT_W-1:0] ecnt);
    cfg_pattern = p; cfg_len = l; cfg_overlap = o; cfg_target = t; cfg_we = 1;
    cycle(0, ecnt, 0, 0);
  endtask

  // Send n valid bits, MSB first; zt marks which bits must complete a hit.
  task automatic stream(input logic [15:0] bits, input logic [15:0] zt, input int n,
                        input logic [CNT_W-1:0] c0, input logic eb, input logic ed,
                        output logic [CNT_W-1:0] c1);
    c1 = c0;
    for (int i = n - 1; i >= 0; i--) begin
      w = bits[i]; w_valid = 1;
      if (zt[i]) c1 = c1 + 1'b1;
      cycle(zt[i], c1, eb, ed);
    end
  endtask

  task automatic test_reset();
    rst = 1;
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    for (int k = 0; exp_q.size() > 0; k++) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL reset#%0d: got z/cnt/busy/done=%b/%0d/%b/%b expected %b/%0d/%b/%b",
                 k, a[CNT_W+2], a[CNT_W+1:2], a[1], a[0], e[CNT_W+2], e[CNT_W+1:2], e[1], e[0]);
      end
    end
  endtask

  task automatic test_overlap();
    configure(8'b1011, 4, 1, 0, 0);
    start = 1; cycle(0, 0, 1, 0);
    stream(16'b1011011, 16'b0001001, 7, 0, 1, 0, c);
    cycle(0, 2, 1, 0);
    for (int k = 0; exp_q.size() > 0; k++) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL overlap#%0d: got z/cnt/busy/done=%b/%0d/%b/%b expected %b/%0d/%b/%b",
                 k, a[CNT_W+2], a[CNT_W+1:2], a[1], a[0], e[CNT_W+2], e[CNT_W+1:2], e[1], e[0]);
      end
    end
  endtask

  task automatic test_no_overlap();
    stop = 1; cycle(0, 2, 0, 0);
    configure(8'b1011, 4, 0, 0, 2);
    start = 1; cycle(0, 0, 1, 0);
    stream(16'b1011011, 16'b0001000, 7, 0, 1, 0, c);
    stop = 1; cycle(0, 1, 0, 0);
    for (int k = 0; exp_q.size() > 0; k++) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL no_overlap#%0d: got z/cnt/busy/done=%b/%0d/%b/%b expected %b/%0d/%b/%b",
                 k, a[CNT_W+2], a[CNT_W+1:2], a[1], a[0], e[CNT_W+2], e[CNT_W+1:2], e[1], e[0]);
      end
    end
  endtask

  task automatic test_target_rearm();
    configure(8'b1011, 4, 1, 2, 1);
    start = 1; cycle(0, 0, 1, 0);
    stream(16'b101101, 16'b000100, 6, 0, 1, 0, c);
    w = 1; w_valid = 1; cycle(1, 2, 0, 1);
    stream(16'b1011, 16'b0000, 4, 2, 0, 1, c);
    start = 1; cycle(0, 0, 1, 0);
    stop = 1; cycle(0, 0, 0, 0);
    for (int k = 0; exp_q.size() > 0; k++) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL target#%0d: got z/cnt/busy/done=%b/%0d/%b/%b expected %b/%0d/%b/%b",
                 k, a[CNT_W+2], a[CNT_W+1:2], a[1], a[0], e[CNT_W+2], e[CNT_W+1:2], e[1], e[0]);
      end
    end
  endtask

  task automatic test_gaps_stop();
    configure(8'b111, 3, 0, 0, 0);
    start = 1; cycle(0, 0, 1, 0);
    w = 1; w_valid = 1; cycle(0, 0, 1, 0);
    w = 1; w_valid = 1; cycle(0, 0, 1, 0);
    w = 0; w_valid = 0; cycle(0, 0, 1, 0);
    w = 1; w_valid = 1; cycle(1, 1, 1, 0);
    w = 1; w_valid = 1; cycle(0, 1, 1, 0);
    w = 1; w_valid = 1; cycle(0, 1, 1, 0);
    w = 1; w_valid = 1; stop = 1; cycle(0, 1, 0, 0);
    cycle(0, 1, 0, 0);
    for (int k = 0; exp_q.size() > 0; k++) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL gaps_stop#%0d: got z/cnt/busy/done=%b/%0d/%b/%b expected %b/%0d/%b/%b",
                 k, a[CNT_W+2], a[CNT_W+1:2], a[1], a[0], e[CNT_W+2], e[CNT_W+1:2], e[1], e[0]);
      end
    end
  endtask

  task automatic test_invalid_cfg();
    configure(8'b111, 0, 0, 0, 1);
    start = 1; cycle(0, 1, 0, 0);
    stream(16'b111, 16'b000, 3, 1, 0, 0, c);
    configure(8'b111, 9, 0, 0, 1);
    start = 1; cycle(0, 1, 0, 0);
    cfg_pattern = 8'b111; cfg_len = 3; cfg_we = 1; start = 1; cycle(0, 1, 0, 0);
    start = 1; cycle(0, 0, 1, 0);
    stream(16'b111, 16'b001, 3, 0, 1, 0, c);
    stop = 1; cycle(0, 1, 0, 0);
    for (int k = 0; exp_q.size() > 0; k++) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL invalid_cfg#%0d: got z/cnt/busy/done=%b/%0d/%b/%b expected %b/%0d/%b/%b",
                 k, a[CNT_W+2], a[CNT_W+1:2], a[1], a[0], e[CNT_W+2], e[CNT_W+1:2], e[1], e[0]);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    configure(8'b1011, 4, 1, 0, 1);
    start = 1; cycle(0, 0, 1, 0);
    stream(16'b101110, 16'b000100, 6, 0, 1, 0, c);
    rst = 1; cycle(0, 0, 0, 0);
    start = 1; cycle(0, 0, 0, 0);
    stream(16'b1011, 16'b0000, 4, 0, 0, 0, c);
    for (int k = 0; exp_q.size() > 0; k++) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL reset_mid#%0d: got z/cnt/busy/done=%b/%0d/%b/%b expected %b/%0d/%b/%b",
                 k, a[CNT_W+2], a[CNT_W+1:2], a[1], a[0], e[CNT_W+2], e[CNT_W+1:2], e[1], e[0]);
      end
    end
  endtask

  initial begin
    clear_pulses();
    cfg_pattern = '0; cfg_len = '0; cfg_overlap = 0; cfg_target = '0;
    test_reset();
    test_overlap();
    test_no_overlap();
    test_target_rearm();
    test_gaps_stop();
    test_invalid_cfg();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
